// File: rtl/ann_sched_pkg.sv
// Shared types and constants for the compare-sweep scheduler.
// Holds the FSM state encoding, the default requester count and counter
// width, and the ceil-log2 helper used to size grant indices.
package ann_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SWEEP = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Smallest r with 2^r >= v; elaborates to a constant.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search begins at index ptr and wraps modulo NREQ; the first active
// request found wins. The pointer itself is owned by the caller.
module rr_arbiter
    import ann_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic found;
    int   idx;

    // Walk the requesters starting at ptr; take the first one that is asking.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/compare_sweep_scheduler.sv
// compare_sweep_scheduler
// Time-shares one counter+compare datapath among NREQ requesters. The winner
// of a round-robin arbitration has its compare value loaded, the shared
// counter is cleared, one full 2^W-cycle sweep is run, and the number of
// cycles with dp_hit high is returned to the requester with a one-cycle ack.
//
// Build option: define SCHED_ABORT_EN to abandon a sweep (no ack, result kept)
// as soon as the served requester drops its request. Without it, every
// granted sweep runs to completion and is acknowledged.
module compare_sweep_scheduler
    import ann_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic              clock,
    input  logic              res,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_val,
    output logic [NREQ-1:0]   ack,
    output logic [W:0]        result,
    output logic              dp_res,
    output logic [W-1:0]      dp_in,
    input  logic              dp_hit,
    output logic              busy
);

    localparam int IW = clog2(NREQ);

    state_e          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   ptr_d;
    logic [IW-1:0]   grant_q;
    logic [W-1:0]    sweep_q;
    logic [W-1:0]    dp_in_q;
    logic [W:0]      hit_q;
    logic [W:0]      hit_d;
    logic [W:0]      result_q;
    logic [NREQ-1:0] ack_q;
    logic            dp_res_q;
    logic            sweep_last;
    logic            abort;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

`ifdef SCHED_ABORT_EN
    assign abort = ~req[grant_q];
`else
    assign abort = 1'b0;
`endif

    assign sweep_last = (sweep_q == {W{1'b1}});
    assign hit_d      = hit_q + {{W{1'b0}}, dp_hit};

    // Next search start is one past the winner, wrapping at NREQ.
    always_comb begin
        ptr_d = arb_idx + 1'b1;
        if (int'(arb_idx) == NREQ - 1) ptr_d = '0;
    end

    // Scheduler FSM: grant latch, sweep counter, hit counter and outputs.
    always_ff @(posedge clock) begin
        if (res) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            sweep_q  <= '0;
            dp_in_q  <= '0;
            hit_q    <= '0;
            result_q <= '0;
            ack_q    <= '0;
            dp_res_q <= 1'b1;
        end else begin
            ack_q <= '0;
            case (state_q)
                S_IDLE: begin
                    dp_res_q <= 1'b1;
                    if (|arb_grant) begin
                        grant_q <= arb_idx;
                        ptr_q   <= ptr_d;
                        dp_in_q <= req_val[int'(arb_idx)*W +: W];
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    hit_q    <= '0;
                    sweep_q  <= '0;
                    dp_res_q <= 1'b0;
                    state_q  <= S_SWEEP;
                end
                S_SWEEP: begin
                    if (abort) begin
                        dp_res_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        sweep_q <= sweep_q + 1'b1;
                        hit_q   <= hit_d;
                        if (sweep_last) begin
                            result_q       <= hit_d;
                            ack_q[grant_q] <= 1'b1;
                            dp_res_q       <= 1'b1;
                            state_q        <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    dp_res_q <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack    = ack_q;
    assign result = result_q;
    assign dp_res = dp_res_q;
    assign dp_in  = dp_in_q;
    assign busy   = (state_q != S_IDLE);

endmodule
